// File: rtl/feature_window_3x3.sv
// rtl/feature_window_3x3.sv - 3x3 sliding-window generator fed from the feature FWFT
// Two line buffers plus a 3x3 register window; emits one window per valid (no-pad, stride-1) position.
module feature_window_3x3 #(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_feature,
  input  logic                in_valid,
  output logic                rd_en,
  output logic [9*DATA_W-1:0] win,
  output logic                win_valid,
  input  logic                win_ready,
  output logic                frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb0 [IMG_W];
  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] w   [9];

  logic adv;
  logic accept;
  logic last_col;
  logic last_row;
  logic pos_valid;

  assign adv       = ~win_valid | win_ready;
  assign rd_en     = rst & in_valid & adv;
  assign accept    = rd_en;
  assign last_col  = (col == COL_LAST);
  assign last_row  = (row == ROW_LAST);
  assign pos_valid = (row >= RW'(2)) && (col >= CW'(2));

  always_ff @(posedge clk) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Line buffers carry no reset: their contents are only read after being rewritten this frame.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[col] <= lb1[col];
      lb1[col] <= in_feature;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 9; k++) w[k] <= '0;
    end else if (accept) begin
      w[0] <= w[1];
      w[1] <= w[2];
      w[2] <= lb0[col];
      w[3] <= w[4];
      w[4] <= w[5];
      w[5] <= lb1[col];
      w[6] <= w[7];
      w[7] <= w[8];
      w[8] <= in_feature;
    end
  end

  // Validity uses pre-increment counters, so col >= 2 keeps windows inside one row.
  always_ff @(posedge clk) begin
    if (!rst) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (accept) begin
      win_valid  <= pos_valid;
      frame_done <= last_col & last_row;
    end else if (win_ready) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

  always_comb begin
    win = '0;
    for (int k = 0; k < 9; k++) win[DATA_W*k +: DATA_W] = w[k];
  end

endmodule

// File: tb/tb_feature_window_3x3.sv
// tb/tb_feature_window_3x3.sv - directed bench for feature_window_3x3 (5x4 and 28x28 instances)
module tb_feature_window_3x3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  s_in_feature;
  logic        s_in_valid, s_rd_en, s_win_valid, s_win_ready, s_frame_done;
  logic [71:0] s_win;
  logic [7:0]  b_in_feature;
  logic        b_in_valid, b_rd_en, b_win_valid, b_win_ready, b_frame_done;
  logic [71:0] b_win;

  feature_window_3x3 #(.IMG_W(5), .IMG_H(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_feature(s_in_feature), .in_valid(s_in_valid),
    .rd_en(s_rd_en), .win(s_win), .win_valid(s_win_valid), .win_ready(s_win_ready),
    .frame_done(s_frame_done)
  );

  feature_window_3x3 dut_big (
    .clk(clk), .rst(rst), .in_feature(b_in_feature), .in_valid(b_in_valid),
    .rd_en(b_rd_en), .win(b_win), .win_valid(b_win_valid), .win_ready(b_win_ready),
    .frame_done(b_frame_done)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] spix [64];
  logic [7:0] bpix [784];

  // Element k=0 sits in the LSBs.
  localparam logic [71:0] W_FIRST  = {8'd12, 8'd11, 8'd10, 8'd7,  8'd6,  8'd5,  8'd2,  8'd1,  8'd0};
  localparam logic [71:0] W_SECOND = {8'd13, 8'd12, 8'd11, 8'd8,  8'd7,  8'd6,  8'd3,  8'd2,  8'd1};
  localparam logic [71:0] W_LAST   = {8'd19, 8'd18, 8'd17, 8'd14, 8'd13, 8'd12, 8'd9,  8'd8,  8'd7};
  localparam logic [71:0] W_F2     = {8'd32, 8'd31, 8'd30, 8'd27, 8'd26, 8'd25, 8'd22, 8'd21, 8'd20};

  function automatic logic [71:0] exp_win(input bit big, input int base, input int n);
    int wd, cw, r, c, idx;
    logic [71:0] e;
    wd = big ? 28 : 5;
    cw = wd - 2;
    r  = 2 + n / cw;
    c  = 2 + n % cw;
    e  = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        idx = base + (r - 2 + i) * wd + (c - 2 + j);
        e[8*(3*i+j) +: 8] = big ? bpix[idx] : spix[idx];
      end
    return e;
  endfunction

  task automatic cyc(input logic v, input logic [7:0] d, input logic rdy,
                     output logic acc, output logic hs, output logic [71:0] w, output logic fd);
    s_in_valid = v; s_in_feature = d; s_win_ready = rdy;
    #1;
    acc = s_rd_en; hs = s_win_valid & rdy; w = s_win; fd = s_frame_done;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    s_in_valid = 1'b1; s_win_ready = 1'b1; s_in_feature = 8'hAA;
    b_in_valid = 1'b1; b_win_ready = 1'b1; b_in_feature = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (s_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b expected 0", s_rd_en); end
    n_vec++; if (s_win_valid !== 1'b0) begin n_err++; $display("FAIL reset_win_valid: got %b expected 0", s_win_valid); end
    n_vec++; if (s_win !== 72'd0) begin n_err++; $display("FAIL reset_win: got %h expected 0", s_win); end
    n_vec++; if (s_frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b expected 0", s_frame_done); end
    n_vec++; if (b_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_big_rd_en: got %b expected 0", b_rd_en); end
    n_vec++; if (b_win_valid !== 1'b0) begin n_err++; $display("FAIL reset_big_win_valid: got %b expected 0", b_win_valid); end
    rst = 1'b1;
    s_in_valid = 1'b0; b_in_valid = 1'b0;
  endtask

  task automatic test_ramp;
    int p, nwin;
    logic acc, hs, fd;
    logic [71:0] w;
    for (int i = 0; i < 20; i++) spix[i] = 8'(i);
    p = 0; nwin = 0;
    for (int t = 0; t < 200 && nwin < 6; t++) begin
      cyc(p < 20, spix[p], 1'b1, acc, hs, w, fd);
      if (hs) begin
        if (nwin == 0) begin
          n_vec++; if (p != 13) begin n_err++; $display("FAIL ramp_latency: first window after %0d pixels, expected 13", p); end
          n_vec++; if (w !== W_FIRST) begin n_err++; $display("FAIL ramp_first: got %h expected %h", w, W_FIRST); end
        end
        if (nwin == 5) begin
          n_vec++; if (w !== W_LAST) begin n_err++; $display("FAIL ramp_last: got %h expected %h", w, W_LAST); end
        end
        n_vec++; if (w !== exp_win(0, 0, nwin)) begin n_err++; $display("FAIL ramp_win%0d: got %h expected %h", nwin, w, exp_win(0, 0, nwin)); end
        n_vec++; if (fd !== (nwin == 5)) begin n_err++; $display("FAIL ramp_frame_done%0d: got %b expected %b", nwin, fd, nwin == 5); end
        nwin++;
      end
      if (acc) p++;
    end
    n_vec++; if (nwin != 6) begin n_err++; $display("FAIL ramp_count: got %0d expected 6", nwin); end
    n_vec++; if (p != 20) begin n_err++; $display("FAIL ramp_pixels: got %0d expected 20", p); end
    cyc(1'b0, 8'd0, 1'b1, acc, hs, w, fd);
    n_vec++; if (s_win_valid !== 1'b0 || fd !== 1'b0) begin n_err++; $display("FAIL ramp_idle: got valid=%b fd=%b expected 0/0", s_win_valid, fd); end
  endtask

  task automatic test_back_to_back;
    int p, nwin;
    logic acc, hs, fd;
    logic [71:0] w;
    for (int i = 0; i < 40; i++) spix[i] = 8'(i);
    p = 0; nwin = 0;
    for (int t = 0; t < 300 && nwin < 12; t++) begin
      cyc(p < 40, spix[p], 1'b1, acc, hs, w, fd);
      if (hs) begin
        if (nwin == 6) begin
          n_vec++; if (w !== W_F2) begin n_err++; $display("FAIL b2b_f2_first: got %h expected %h", w, W_F2); end
        end
        n_vec++; if (w !== exp_win(0, (nwin / 6) * 20, nwin % 6)) begin n_err++; $display("FAIL b2b_win%0d: got %h expected %h", nwin, w, exp_win(0, (nwin / 6) * 20, nwin % 6)); end
        n_vec++; if (fd !== (nwin % 6 == 5)) begin n_err++; $display("FAIL b2b_frame_done%0d: got %b expected %b", nwin, fd, nwin % 6 == 5); end
        nwin++;
      end
      if (acc) p++;
    end
    n_vec++; if (nwin != 12) begin n_err++; $display("FAIL b2b_count: got %0d expected 12", nwin); end
  endtask

  task automatic test_backpressure;
    int p, nwin, held;
    logic acc, hs, fd, rdy;
    logic [71:0] w;
    for (int i = 0; i < 20; i++) spix[i] = 8'(i);
    p = 0; nwin = 0; held = 0;
    for (int t = 0; t < 200 && nwin < 6; t++) begin
      rdy = 1'b1;
      if (s_win_valid && held < 5) begin rdy = 1'b0; held++; end
      cyc(p < 20, spix[p], rdy, acc, hs, w, fd);
      if (!rdy) begin
        n_vec++; if (acc !== 1'b0) begin n_err++; $display("FAIL bp_rd_en: got %b expected 0", acc); end
        n_vec++; if (w !== W_FIRST) begin n_err++; $display("FAIL bp_hold: got %h expected %h", w, W_FIRST); end
      end
      if (hs) begin
        if (nwin == 1) begin
          n_vec++; if (w !== W_SECOND) begin n_err++; $display("FAIL bp_second: got %h expected %h", w, W_SECOND); end
        end
        n_vec++; if (w !== exp_win(0, 0, nwin)) begin n_err++; $display("FAIL bp_win%0d: got %h expected %h", nwin, w, exp_win(0, 0, nwin)); end
        nwin++;
      end
      if (acc) p++;
    end
    n_vec++; if (nwin != 6 || held != 5) begin n_err++; $display("FAIL bp_count: got %0d windows %0d stalls expected 6 and 5", nwin, held); end
  endtask

  task automatic test_gaps;
    int p, nwin;
    logic acc, hs, fd, v;
    logic [71:0] w;
    for (int i = 0; i < 20; i++) spix[i] = 8'(i);
    p = 0; nwin = 0;
    for (int t = 0; t < 400 && nwin < 6; t++) begin
      v = (p < 20) && ($urandom_range(0, 1) == 1);
      cyc(v, v ? spix[p] : 8'hEE, 1'b1, acc, hs, w, fd);
      if (!v) begin
        n_vec++; if (acc !== 1'b0) begin n_err++; $display("FAIL gap_rd_en: got %b expected 0", acc); end
      end
      if (hs) begin
        n_vec++; if (w !== exp_win(0, 0, nwin)) begin n_err++; $display("FAIL gap_win%0d: got %h expected %h", nwin, w, exp_win(0, 0, nwin)); end
        n_vec++; if (fd !== (nwin == 5)) begin n_err++; $display("FAIL gap_frame_done%0d: got %b expected %b", nwin, fd, nwin == 5); end
        nwin++;
      end
      if (acc) p++;
    end
    n_vec++; if (nwin != 6) begin n_err++; $display("FAIL gap_count: got %0d expected 6", nwin); end
  endtask

  task automatic test_mid_reset;
    int p, nwin;
    logic acc, hs, fd;
    logic [71:0] w;
    for (int i = 0; i < 20; i++) spix[i] = 8'(i);
    p = 0;
    for (int t = 0; t < 50 && p < 10; t++) begin
      cyc(1'b1, spix[p], 1'b1, acc, hs, w, fd);
      if (acc) p++;
    end
    rst = 1'b0; s_in_valid = 1'b1; s_in_feature = 8'd10; s_win_ready = 1'b1;
    #1;
    n_vec++; if (s_rd_en !== 1'b0) begin n_err++; $display("FAIL mrst_rd_en: got %b expected 0", s_rd_en); end
    @(posedge clk); #1;
    n_vec++; if (s_win !== 72'd0) begin n_err++; $display("FAIL mrst_win: got %h expected 0", s_win); end
    n_vec++; if (s_win_valid !== 1'b0 || s_frame_done !== 1'b0) begin n_err++; $display("FAIL mrst_flags: got valid=%b fd=%b expected 0/0", s_win_valid, s_frame_done); end
    rst = 1'b1;
    p = 0; nwin = 0;
    for (int t = 0; t < 200 && nwin < 6; t++) begin
      cyc(p < 20, spix[p], 1'b1, acc, hs, w, fd);
      if (hs) begin
        n_vec++; if (w !== exp_win(0, 0, nwin)) begin n_err++; $display("FAIL mrst_win%0d: got %h expected %h", nwin, w, exp_win(0, 0, nwin)); end
        n_vec++; if (fd !== (nwin == 5)) begin n_err++; $display("FAIL mrst_frame_done%0d: got %b expected %b", nwin, fd, nwin == 5); end
        nwin++;
      end
      if (acc) p++;
    end
    n_vec++; if (nwin != 6) begin n_err++; $display("FAIL mrst_count: got %0d expected 6", nwin); end
  endtask

  task automatic test_big_frame;
    int p, nwin;
    logic acc, hs, fd;
    logic [71:0] w;
    for (int i = 0; i < 784; i++) bpix[i] = 8'($urandom_range(0, 255));
    p = 0; nwin = 0;
    for (int t = 0; t < 3000 && nwin < 676; t++) begin
      b_in_valid = (p < 784); b_in_feature = (p < 784) ? bpix[p] : 8'd0; b_win_ready = 1'b1;
      #1;
      acc = b_rd_en; hs = b_win_valid; w = b_win; fd = b_frame_done;
      @(posedge clk); #1;
      if (hs) begin
        n_vec++; if (w !== exp_win(1, 0, nwin)) begin n_err++; $display("FAIL big_win%0d: got %h expected %h", nwin, w, exp_win(1, 0, nwin)); end
        n_vec++; if (fd !== (nwin == 675)) begin n_err++; $display("FAIL big_frame_done%0d: got %b expected %b", nwin, fd, nwin == 675); end
        nwin++;
      end
      if (acc) p++;
    end
    b_in_valid = 1'b0;
    n_vec++; if (nwin != 676) begin n_err++; $display("FAIL big_count: got %0d expected 676", nwin); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_back_to_back();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_big_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
